// File: rtl/banked_regfile_if.sv
// banked_regfile_if: decoder/ALU-side bus of the banked register file
interface banked_regfile_if #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int NBANKS = 2,
  parameter int TRAPW  = 4
);
  localparam int SW = $clog2(NREGS);
  localparam int LW = $clog2(NBANKS);
  logic [SW-1:0]    rd0_sel_i, rd1_sel_i, wr_sel_i;
  logic [WIDTH-1:0] rd0_data_o, rd1_data_o, wr_data_i, pc_out_o;
  logic             wr_en_i, incr_pc_i, pc_rewind_i, incr_sp_i, decr_sp_i;
  logic             trap_req_i, trap_ack_o, reti_i;
  logic [TRAPW-1:0] trap_nr_i;
  logic [LW-1:0]    level_o;
  logic [1:0]       err_o;
  modport slave (
    input  rd0_sel_i, rd1_sel_i, wr_en_i, wr_sel_i, wr_data_i, incr_pc_i, pc_rewind_i,
           incr_sp_i, decr_sp_i, trap_req_i, trap_nr_i, reti_i,
    output rd0_data_o, rd1_data_o, trap_ack_o, level_o, pc_out_o, err_o
  );
  modport master (
    output rd0_sel_i, rd1_sel_i, wr_en_i, wr_sel_i, wr_data_i, incr_pc_i, pc_rewind_i,
           incr_sp_i, decr_sp_i, trap_req_i, trap_nr_i, reti_i,
    input  rd0_data_o, rd1_data_o, trap_ack_o, level_o, pc_out_o, err_o
  );
endinterface

// File: rtl/banked_regfile.sv
// banked_regfile: register banks with zero/SP/PC per bank and a trap-nesting level stack
module banked_regfile #(
  parameter int               WIDTH  = 16,
  parameter int               NREGS  = 8,
  parameter int               NBANKS = 2,
  parameter int               STEP   = 2,
  parameter logic [WIDTH-1:0] IVEC   = 16'h0004,
  parameter int               TRAPW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  banked_regfile_if.slave  bus
);
  localparam int SW = $clog2(NREGS);
  localparam int LW = $clog2(NBANKS);
  localparam logic [SW-1:0]    SPI = SW'(NREGS - 2);
  localparam logic [SW-1:0]    PCI = SW'(NREGS - 1);
  localparam logic [LW-1:0]    TOP = LW'(NBANKS - 1);
  localparam logic [WIDTH-1:0] INC = WIDTH'(STEP);
  logic [WIDTH-1:0] regs_q [NBANKS][NREGS];
  logic [WIDTH-1:0] regs_d [NBANKS][NREGS];
  logic [LW-1:0]    level_q, level_d;
  logic             ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] pc, sp;
  logic             take, ret;
  // Register 0 is never written, so it reads as zero without a read-side mux.
  always_comb begin
    pc      = regs_q[level_q][PCI];
    sp      = regs_q[level_q][SPI];
    take    = bus.trap_req_i && level_q != TOP;
    ret     = bus.reti_i && !bus.trap_req_i;
    regs_d  = regs_q;
    level_d = level_q;
    ack_d   = take;
    err_d   = err_q;
    if (bus.wr_en_i && bus.wr_sel_i != '0) regs_d[level_q][bus.wr_sel_i] = bus.wr_data_i;
    regs_d[level_q][PCI] = bus.pc_rewind_i ? pc - INC : bus.incr_pc_i ? pc + INC : regs_d[level_q][PCI];
    regs_d[level_q][SPI] = bus.incr_sp_i ? sp + INC : bus.decr_sp_i ? sp - INC : regs_d[level_q][SPI];
    if (take) begin
      regs_d[level_q + 1'b1][1] = WIDTH'(bus.trap_nr_i);
      level_d = level_q + 1'b1;
    end else if (bus.trap_req_i) begin
      err_d[0] = 1'b1;
    end
    if (ret && level_q != '0) begin
      regs_d[level_q][PCI] = IVEC;
      level_d = level_q - 1'b1;
    end else if (ret) begin
      err_d[1] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANKS; b++)
        for (int r = 0; r < NREGS; r++)
          regs_q[b][r] <= (b != 0 && r == NREGS - 1) ? IVEC : '0;
      level_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      regs_q  <= regs_d;
      level_q <= level_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  assign bus.rd0_data_o = regs_q[level_q][bus.rd0_sel_i];
  assign bus.rd1_data_o = regs_q[level_q][bus.rd1_sel_i];
  assign bus.pc_out_o   = regs_q[level_q][PCI];
  assign bus.level_o    = level_q;
  assign bus.trap_ack_o = ack_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed scoreboard bench for banked_regfile (default parameters)
module tb_banked_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;
  exp_t sb[$];
  banked_regfile_if bus ();
  banked_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic push(input string t, input logic [15:0] v);
    sb.push_back('{t, v});
  endtask
  task automatic pop(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic idle();
    bus.wr_en_i = 0; bus.incr_pc_i = 0; bus.pc_rewind_i = 0; bus.incr_sp_i = 0;
    bus.decr_sp_i = 0; bus.trap_req_i = 0; bus.reti_i = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] sel, input logic [15:0] d);
    bus.wr_en_i = 1; bus.wr_sel_i = sel; bus.wr_data_i = d;
  endtask
  function automatic logic [15:0] lvl();
    return 16'(bus.level_o);
  endfunction
  initial begin
    idle();
    bus.rd0_sel_i = 0; bus.rd1_sel_i = 0; bus.wr_sel_i = 0; bus.wr_data_i = 0; bus.trap_nr_i = 0;
    #12;
    push("rst_level", 0); push("rst_pc", 0); push("rst_ack", 0); push("rst_err", 0);
    pop(lvl()); pop(bus.pc_out_o); pop(16'(bus.trap_ack_o)); pop(16'(bus.err_o));
    @(negedge clk) rst_n = 1;
    tick();
    bus.trap_req_i = 1; bus.trap_nr_i = 0;
    push("t1_level", 1); push("t1_ack", 1); push("t1_bank1_pc", 16'h0004); push("t1_err", 0);
    tick(); idle();
    pop(lvl()); pop(16'(bus.trap_ack_o)); pop(bus.pc_out_o); pop(16'(bus.err_o));
    bus.reti_i = 1;
    push("t1_reti_level", 0); push("t1_reti_ack", 0); push("t1_bank0_pc", 0);
    tick(); idle();
    pop(lvl()); pop(16'(bus.trap_ack_o)); pop(bus.pc_out_o);
    wr(3, 16'hBEEF);
    tick(); idle();
    bus.incr_pc_i = 1;
    tick(); tick(); tick(); idle();
    bus.rd0_sel_i = 3; #1;
    push("r3_beef", 16'hBEEF); push("pc_x3", 16'h0006);
    pop(bus.rd0_data_o); pop(bus.pc_out_o);
    wr(2, 16'h55AA); bus.rd1_sel_i = 2; #1;
    push("no_bypass", 0); pop(bus.rd1_data_o);
    tick(); idle();
    push("r2_after_edge", 16'h55AA); pop(bus.rd1_data_o);
    wr(0, 16'h1234);
    tick(); idle();
    bus.rd0_sel_i = 0; bus.rd1_sel_i = 0; #1;
    push("r0_port0", 0); push("r0_port1", 0);
    pop(bus.rd0_data_o); pop(bus.rd1_data_o);
    bus.trap_req_i = 1; bus.trap_nr_i = 5; bus.incr_pc_i = 1;
    tick(); idle();
    bus.rd0_sel_i = 1; bus.rd1_sel_i = 3; #1;
    push("t3_level", 1); push("t3_ack", 1); push("t3_r1_trapnr", 16'h0005);
    push("t3_bank1_r3", 0); push("t3_pc_ivec", 16'h0004);
    pop(lvl()); pop(16'(bus.trap_ack_o)); pop(bus.rd0_data_o); pop(bus.rd1_data_o); pop(bus.pc_out_o);
    tick();
    push("t3_ack_pulse", 0); push("t3_level_hold", 1);
    pop(16'(bus.trap_ack_o)); pop(lvl());
    bus.incr_pc_i = 1;
    tick(); idle();
    push("t3_bank1_incr", 16'h0006); pop(bus.pc_out_o);
    bus.reti_i = 1; bus.incr_pc_i = 1;
    tick(); idle();
    bus.rd0_sel_i = 3; bus.rd1_sel_i = 2; #1;
    push("t3_reti_level", 0); push("t3_bank0_pc_trapcycle", 16'h0008);
    push("t3_bank0_r3", 16'hBEEF); push("t3_bank0_r2", 16'h55AA);
    pop(lvl()); pop(bus.pc_out_o); pop(bus.rd0_data_o); pop(bus.rd1_data_o);
    bus.trap_req_i = 1; bus.reti_i = 1; bus.trap_nr_i = 7;
    tick(); idle();
    bus.rd0_sel_i = 1; #1;
    push("both_level", 1); push("both_ack", 1); push("reti_ivec_override", 16'h0004);
    push("both_r1", 16'h0007); push("both_err", 0);
    pop(lvl()); pop(16'(bus.trap_ack_o)); pop(bus.pc_out_o); pop(bus.rd0_data_o); pop(16'(bus.err_o));
    bus.reti_i = 1;
    tick(); idle();
    push("both_back", 0); pop(lvl());
    bus.trap_req_i = 1; bus.trap_nr_i = 9;
    tick(); idle();
    push("t4_level", 1); pop(lvl());
    bus.trap_req_i = 1; bus.trap_nr_i = 3;
    tick(); idle();
    #1;
    push("ovf_level", 1); push("ovf_ack", 0); push("ovf_err", 1); push("ovf_r1_kept", 16'h0009);
    pop(lvl()); pop(16'(bus.trap_ack_o)); pop(16'(bus.err_o)); pop(bus.rd0_data_o);
    bus.reti_i = 1;
    tick(); idle();
    push("t4_reti_level", 0); push("t4_err_sticky", 1);
    pop(lvl()); pop(16'(bus.err_o));
    bus.reti_i = 1;
    tick(); idle();
    push("udf_level", 0); push("udf_err", 3); push("udf_pc", 16'h0008);
    pop(lvl()); pop(16'(bus.err_o)); pop(bus.pc_out_o);
    bus.rd0_sel_i = 6;
    bus.decr_sp_i = 1;
    tick(); idle();
    push("sp_wrap", 16'hFFFE); pop(bus.rd0_data_o);
    bus.incr_sp_i = 1; bus.decr_sp_i = 1;
    tick(); idle();
    push("sp_incr_wins", 16'h0000); pop(bus.rd0_data_o);
    wr(6, 16'h1000); bus.incr_sp_i = 1;
    tick(); idle();
    push("sp_incr_over_wr", 16'h0002); pop(bus.rd0_data_o);
    bus.pc_rewind_i = 1; bus.incr_pc_i = 1;
    tick(); idle();
    push("pc_rewind_wins", 16'h0006); pop(bus.pc_out_o);
    wr(7, 16'h0100);
    tick(); idle();
    push("pc_write", 16'h0100); pop(bus.pc_out_o);
    wr(7, 16'h2222); bus.incr_pc_i = 1;
    tick(); idle();
    push("pc_incr_over_wr", 16'h0102); pop(bus.pc_out_o);
    bus.trap_req_i = 1; bus.trap_nr_i = 2;
    tick(); idle();
    push("t6_level", 1); push("t6_ack", 1);
    pop(lvl()); pop(16'(bus.trap_ack_o));
    #2 rst_n = 0;
    #1 bus.rd0_sel_i = 3; bus.rd1_sel_i = 6;
    #1;
    push("arst_level", 0); push("arst_ack", 0); push("arst_err", 0);
    push("arst_pc", 0); push("arst_r3", 0); push("arst_sp", 0);
    pop(lvl()); pop(16'(bus.trap_ack_o)); pop(16'(bus.err_o));
    pop(bus.pc_out_o); pop(bus.rd0_data_o); pop(bus.rd1_data_o);
    bus.rd0_sel_i = 2; #1;
    push("arst_r2", 0); pop(bus.rd0_data_o);
    @(negedge clk) rst_n = 1;
    bus.trap_req_i = 1; bus.trap_nr_i = 1;
    tick(); idle();
    push("post_rst_level", 1); push("post_rst_bank1_pc", 16'h0004);
    pop(lvl()); pop(bus.pc_out_o);
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
